i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Parameters
REQ-001 The block SHALL expose TIMEOUT, default 1023, the maximum number of clk cycles spent in ISSUE or BUSY before the transaction is aborted (range 1..1023).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 2 bits: per-requester transaction request, held high until the matching ack.
REQ-005 The block SHALL have ports req_addr0 and req_addr1, input, 7 bits each: per-requester slave address.
REQ-006 The block SHALL have ports req_rw0 and req_rw1, input, 1 bit each: per-requester direction, 1 = read, 0 = write.
REQ-007 The block SHALL have ports req_wdata0 and req_wdata1, input, 8 bits each: per-requester write byte.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant, held for the whole transaction.
REQ-009 The block SHALL have port ack, output, 2 bits: one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port rdata, output, 8 bits: read byte, valid in the ack cycle.
REQ-011 The block SHALL have port timeout_err, output, 1 bit: high in the ack cycle when the transaction was aborted.
REQ-012 The block SHALL have ports core_en (1 bit), core_addr (7 bits), core_rw (1 bit) and core_wdata (8 bits), outputs: drive the I2C master core.
REQ-013 The block SHALL have port core_busy, input, 1 bit: high while the core runs a transaction.
REQ-014 The block SHALL have port core_rdata, input, 8 bits: byte read by the core.

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, ISSUE, BUSY and DONE, plus a 1-bit last-served pointer (last) and a 10-bit cycle counter (cnt).
REQ-016 In IDLE with req != 0, the block SHALL grant the only requester if one is requesting; if both are requesting it SHALL grant the one not equal to last.
REQ-017 At the grant, in the same edge, the block SHALL latch the granted requester's addr, rw and wdata into core_addr, core_rw and core_wdata, set gnt, clear cnt, and go to ISSUE.
REQ-018 In ISSUE, core_en SHALL be 1; when core_busy = 1 is sampled, the block SHALL clear cnt and go to BUSY.
REQ-019 In BUSY, core_en SHALL be 0; when core_busy = 0 is sampled, the block SHALL capture core_rdata into rdata if core_rw = 1 and go to DONE.
REQ-020 In ISSUE and BUSY, cnt SHALL increment every cycle; when cnt = TIMEOUT, the block SHALL set timeout_err, leave rdata unchanged, drop core_en, and go to DONE.
REQ-021 In DONE, for exactly one cycle, the block SHALL assert ack[g] = 1 with gnt still high; on the next edge it SHALL clear gnt, ack and timeout_err, set last = g, and go to IDLE.
REQ-022 Fairness: consecutive grants SHALL alternate whenever both req bits stay high, and the minimum gap between one ack and the next grant SHALL be one IDLE cycle.
REQ-023 The block SHALL ignore a req deasserted mid-transaction; the transaction completes and still pulses ack.
REQ-024 The block SHALL ignore changes to req_* inputs after the grant, because the latched values drive the core.
REQ-025 The block SHALL ignore core_busy while in IDLE or DONE.
REQ-026 gnt and ack SHALL never have more than one bit set.
REQ-027 core_addr, core_rw and core_wdata SHALL hold their values between transactions.

Reset
REQ-028 When resetN = 0, the block SHALL immediately force: state = IDLE, gnt = 0, ack = 0, core_en = 0, core_addr = 0, core_rw = 0, core_wdata = 0, rdata = 0, timeout_err = 0, cnt = 0, last = 1 (so requester 0 wins the first tie).
REQ-029 A reset mid-transaction SHALL abandon the transaction with no ack; the requester re-requests.
REQ-030 The block SHALL leave reset synchronously, with the first grant possible on the first clk edge after resetN rises.

Verification
REQ-031 Single write: req = 01, addr0 = 0x50, rw0 = 0, wdata0 = 0xA5; core raises busy 3 cycles later for 20 cycles -> core_en high 3 cycles, core_addr = 0x50, core_wdata = 0xA5, ack = 01 one cycle, timeout_err = 0.
REQ-032 Read: req = 10, rw1 = 1, core_rdata = 0x3C when busy falls -> rdata = 0x3C in the ack = 10 cycle.
REQ-033 Tie after reset: req = 11 held for four transactions -> grant order 0, 1, 0, 1, one IDLE cycle between each ack and the next gnt.
REQ-034 Timeout: TIMEOUT = 15, core_busy held 0 -> ISSUE lasts 16 cycles, then ack with timeout_err = 1, rdata unchanged.
REQ-035 Reset mid-BUSY: resetN pulsed low -> all outputs 0 immediately, no ack; the next req = 01 is served normally.
REQ-036 Stuck busy: core_busy held 1 for longer than TIMEOUT in BUSY -> ack with timeout_err = 1, and the next transaction is granted to the other requester.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the I2C master core.
// The master modport is the arbiter's view. The slave modport is the view of
// the environment that drives requests and models the core.
interface i2c_arbiter_if;
   logic [1:0] req;
   logic [6:0] req_addr0;
   logic [6:0] req_addr1;
   logic       req_rw0;
   logic       req_rw1;
   logic [7:0] req_wdata0;
   logic [7:0] req_wdata1;
   logic [1:0] gnt;
   logic [1:0] ack;
   logic [7:0] rdata;
   logic       timeout_err;
   logic       core_en;
   logic [6:0] core_addr;
   logic       core_rw;
   logic [7:0] core_wdata;
   logic       core_busy;
   logic [7:0] core_rdata;

   modport master (
      input  req, req_addr0, req_addr1, req_rw0, req_rw1, req_wdata0, req_wdata1,
      input  core_busy, core_rdata,
      output gnt, ack, rdata, timeout_err,
      output core_en, core_addr, core_rw, core_wdata
   );

   modport slave (
      output req, req_addr0, req_addr1, req_rw0, req_rw1, req_wdata0, req_wdata1,
      output core_busy, core_rdata,
      input  gnt, ack, rdata, timeout_err,
      input  core_en, core_addr, core_rw, core_wdata
   );
endinterface

// File: rtl/i2c_arbiter.sv
// Two-requester arbiter in front of a single I2C master core.
// Ties alternate using a last-served pointer. The request that wins is latched
// and drives the core. A per-transaction cycle counter aborts a hung core. All
// outputs are registers.
module i2c_arbiter #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          resetN,
   i2c_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

   state_t     state_r;
   logic       last_r;
   logic [9:0] cnt_r;
   logic       gidx_r;
   logic [1:0] gnt_r;
   logic [1:0] ack_r;
   logic [7:0] rdata_r;
   logic       terr_r;
   logic       core_en_r;
   logic [6:0] core_addr_r;
   logic       core_rw_r;
   logic [7:0] core_wdata_r;

   logic       pick_s;
   logic [6:0] sel_addr_s;
   logic       sel_rw_s;
   logic [7:0] sel_wdata_s;

   // Index of a requester, turned into its one-hot grant vector.
   function automatic logic [1:0] idx_to_onehot(input logic idx);
      logic [1:0] oh;
      if (idx) begin
         oh = 2'b10;
      end else begin
         oh = 2'b01;
      end
      return oh;
   endfunction

   // Winner selection: a lone requester wins, and a tie goes to the one not served last.
   always_comb begin
      if (bus.req == 2'b11) begin
         pick_s = ~last_r;
      end else if (bus.req[1]) begin
         pick_s = 1'b1;
      end else begin
         pick_s = 1'b0;
      end
   end

   // Route the winner's transaction fields towards the core latches.
   always_comb begin
      if (pick_s) begin
         sel_addr_s  = bus.req_addr1;
         sel_rw_s    = bus.req_rw1;
         sel_wdata_s = bus.req_wdata1;
      end else begin
         sel_addr_s  = bus.req_addr0;
         sel_rw_s    = bus.req_rw0;
         sel_wdata_s = bus.req_wdata0;
      end
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_r      <= IDLE;
         last_r       <= 1'b1;
         cnt_r        <= 10'd0;
         gidx_r       <= 1'b0;
         gnt_r        <= 2'b00;
         ack_r        <= 2'b00;
         rdata_r      <= 8'h00;
         terr_r       <= 1'b0;
         core_en_r    <= 1'b0;
         core_addr_r  <= 7'h00;
         core_rw_r    <= 1'b0;
         core_wdata_r <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req != 2'b00) begin
                  gidx_r       <= pick_s;
                  gnt_r        <= idx_to_onehot(pick_s);
                  core_addr_r  <= sel_addr_s;
                  core_rw_r    <= sel_rw_s;
                  core_wdata_r <= sel_wdata_s;
                  cnt_r        <= 10'd0;
                  core_en_r    <= 1'b1;
                  state_r      <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.core_busy) begin
                  cnt_r     <= 10'd0;
                  core_en_r <= 1'b0;
                  state_r   <= BUSY;
               end else if (cnt_r == TIMEOUT_C) begin
                  // The core never started. Abort and leave rdata untouched.
                  terr_r    <= 1'b1;
                  core_en_r <= 1'b0;
                  ack_r     <= gnt_r;
                  state_r   <= DONE;
               end else begin
                  cnt_r <= cnt_r + 10'd1;
               end
            end
            BUSY: begin
               if (!bus.core_busy) begin
                  if (core_rw_r) begin
                     rdata_r <= bus.core_rdata;
                  end
                  ack_r   <= gnt_r;
                  state_r <= DONE;
               end else if (cnt_r == TIMEOUT_C) begin
                  // The core is stuck busy. Give up on it.
                  terr_r  <= 1'b1;
                  ack_r   <= gnt_r;
                  state_r <= DONE;
               end else begin
                  cnt_r <= cnt_r + 10'd1;
               end
            end
            DONE: begin
               gnt_r   <= 2'b00;
               ack_r   <= 2'b00;
               terr_r  <= 1'b0;
               last_r  <= gidx_r;
               state_r <= IDLE;
            end
            default: begin
               gnt_r     <= 2'b00;
               ack_r     <= 2'b00;
               terr_r    <= 1'b0;
               core_en_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt         = gnt_r;
   assign bus.ack         = ack_r;
   assign bus.rdata       = rdata_r;
   assign bus.timeout_err = terr_r;
   assign bus.core_en     = core_en_r;
   assign bus.core_addr   = core_addr_r;
   assign bus.core_rw     = core_rw_r;
   assign bus.core_wdata  = core_wdata_r;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed scoreboard bench. Two arbiters share the clock and reset: b0 keeps
// the default TIMEOUT, and b1 uses TIMEOUT = 15 for the abort cases. Each
// stimulus pushes its expected ack record. A negedge monitor pops and compares.
module tb_i2c_arbiter;

   typedef struct {
      logic [1:0] ack;
      logic [7:0] rdata;
      logic       terr;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       rw;
   } exp_t;

   logic clk;
   logic resetN;
   int   n_chk;
   int   n_pass;
   exp_t q0[$];
   exp_t q1[$];

   i2c_arbiter_if b0 ();
   i2c_arbiter_if b1 ();

   i2c_arbiter dut0 (.clk(clk), .resetN(resetN), .bus(b0));
   i2c_arbiter #(.TIMEOUT(15)) dut1 (.clk(clk), .resetN(resetN), .bus(b1));

   // Core model state, one slot per arbiter instance.
   int         core_mode[2];   // 0 normal, 1 never busy, 2 busy never drops
   int         core_delay[2];
   int         core_len[2];
   logic [7:0] rd_next[2];
   int         en_cnt[2];
   int         busy_left[2];
   logic       cb[2];
   logic [7:0] crd[2];
   logic       en_o[2];
   logic [1:0] ack_o[2];
   logic [1:0] gnt_o[2];

   assign b0.core_busy  = cb[0];
   assign b1.core_busy  = cb[1];
   assign b0.core_rdata = crd[0];
   assign b1.core_rdata = crd[1];
   assign en_o[0]  = b0.core_en;
   assign en_o[1]  = b1.core_en;
   assign ack_o[0] = b0.ack;
   assign ack_o[1] = b1.ack;
   assign gnt_o[0] = b0.gnt;
   assign gnt_o[1] = b1.gnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ack(input string tag, input exp_t e, input logic [1:0] ack,
                            input logic [1:0] gnt, input logic [7:0] rd, input logic te,
                            input logic [6:0] ad, input logic [7:0] wd, input logic rw);
      chk({tag, "_ack"},   32'(ack), 32'(e.ack));
      chk({tag, "_gnt"},   32'(gnt), 32'(e.ack));
      chk({tag, "_rdata"}, 32'(rd),  32'(e.rdata));
      chk({tag, "_terr"},  32'(te),  32'(e.terr));
      chk({tag, "_addr"},  32'(ad),  32'(e.addr));
      chk({tag, "_wdata"}, 32'(wd),  32'(e.wdata));
      chk({tag, "_rw"},    32'(rw),  32'(e.rw));
   endtask

   // Core model: raise busy after core_delay enabled cycles, hold it for core_len cycles.
   initial begin
      for (int k = 0; k < 2; k++) begin
         cb[k] = 1'b0; crd[k] = 8'h00; en_cnt[k] = 0; busy_left[k] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (!resetN) begin
               cb[k] = 1'b0;
               en_cnt[k] = 0;
            end else if (cb[k]) begin
               if (core_mode[k] != 2 && busy_left[k] <= 1) begin
                  cb[k]  = 1'b0;
                  crd[k] = rd_next[k];
               end else if (busy_left[k] > 1) begin
                  busy_left[k]--;
               end
            end else if (en_o[k] && core_mode[k] != 1) begin
               en_cnt[k]++;
               if (en_cnt[k] >= core_delay[k]) begin
                  cb[k] = 1'b1;
                  busy_left[k] = core_len[k];
                  en_cnt[k] = 0;
               end
            end else begin
               en_cnt[k] = 0;
            end
         end
      end
   end

   // Monitor: compare every ack against the scoreboard and check the one-hot property each cycle.
   always @(negedge clk) begin
      if (b0.ack != 2'b00) begin
         if (q0.size() == 0) chk("b0_unexpected_ack", 32'(b0.ack), 32'd0);
         else check_ack("b0", q0.pop_front(), b0.ack, b0.gnt, b0.rdata, b0.timeout_err,
                        b0.core_addr, b0.core_wdata, b0.core_rw);
      end
      if (b1.ack != 2'b00) begin
         if (q1.size() == 0) chk("b1_unexpected_ack", 32'(b1.ack), 32'd0);
         else check_ack("b1", q1.pop_front(), b1.ack, b1.gnt, b1.rdata, b1.timeout_err,
                        b1.core_addr, b1.core_wdata, b1.core_rw);
      end
      chk("onehot", 32'($countones(b0.gnt) <= 1 && $countones(b0.ack) <= 1 &&
                        $countones(b1.gnt) <= 1 && $countones(b1.ack) <= 1), 32'd1);
   end

   task automatic wait_gnt(input int k, input int max);
      bit got = 1'b0;
      for (int i = 0; i < max && !got; i++) begin
         @(negedge clk);
         if (gnt_o[k] != 2'b00) got = 1'b1;
      end
      chk("gnt_wait", 32'(got), 32'd1);
   endtask

   task automatic wait_ack(input int k, input int max, output int en_cyc);
      bit got = 1'b0;
      en_cyc = 0;
      for (int i = 0; i < max && !got; i++) begin
         @(negedge clk);
         if (en_o[k]) en_cyc++;
         if (ack_o[k] != 2'b00) got = 1'b1;
      end
      chk("ack_wait", 32'(got), 32'd1);
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      int en_cyc;
      int gap;
      bit got;
      n_chk = 0; n_pass = 0;
      resetN = 1'b0;
      for (int k = 0; k < 2; k++) begin
         core_mode[k] = 0; core_delay[k] = 3; core_len[k] = 20; rd_next[k] = 8'h00;
      end
      b0.req = 2'b00; b0.req_addr0 = 7'h00; b0.req_addr1 = 7'h00; b0.req_rw0 = 1'b0;
      b0.req_rw1 = 1'b0; b0.req_wdata0 = 8'h00; b0.req_wdata1 = 8'h00;
      b1.req = 2'b00; b1.req_addr0 = 7'h00; b1.req_addr1 = 7'h00; b1.req_rw0 = 1'b0;
      b1.req_rw1 = 1'b0; b1.req_wdata0 = 8'h00; b1.req_wdata1 = 8'h00;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_gnt",   32'(b0.gnt), 32'd0);
      chk("rst_ack",   32'(b0.ack), 32'd0);
      chk("rst_en",    32'(b0.core_en), 32'd0);
      chk("rst_addr",  32'({b0.core_addr, b0.core_rw, b0.core_wdata}), 32'd0);
      chk("rst_rdata", 32'({b0.rdata, b0.timeout_err}), 32'd0);
      resetN = 1'b1;

      // Single write from requester 0. Busy comes 3 enabled cycles later and lasts 20.
      b0.req_addr0 = 7'h50; b0.req_rw0 = 1'b0; b0.req_wdata0 = 8'hA5; rd_next[0] = 8'hEE;
      q0.push_back('{ack:2'b01, rdata:8'h00, terr:1'b0, addr:7'h50, wdata:8'hA5, rw:1'b0});
      b0.req = 2'b01;
      wait_ack(0, 200, en_cyc);
      chk("write_en_cycles", 32'(en_cyc), 32'd3);
      b0.req = 2'b00;

      // Read from requester 1. The request drops and the fields change after the grant.
      b0.req_addr1 = 7'h21; b0.req_rw1 = 1'b1; b0.req_wdata1 = 8'h77; rd_next[0] = 8'h3C;
      core_delay[0] = 2; core_len[0] = 5;
      q0.push_back('{ack:2'b10, rdata:8'h3C, terr:1'b0, addr:7'h21, wdata:8'h77, rw:1'b1});
      b0.req = 2'b10;
      wait_gnt(0, 20);
      b0.req = 2'b00; b0.req_addr1 = 7'h7F; b0.req_wdata1 = 8'h00; b0.req_rw1 = 1'b0;
      wait_ack(0, 100, en_cyc);

      // Reset during BUSY: everything clears at once and the re-request is served.
      b0.req_addr0 = 7'h33; b0.req_wdata0 = 8'h44; b0.req_rw0 = 1'b0;
      core_delay[0] = 2; core_len[0] = 30;
      b0.req = 2'b01;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (cb[0]) got = 1'b1;
      end
      chk("busy_seen", 32'(got), 32'd1);
      repeat (2) @(negedge clk);
      chk("busy_state_en", 32'(b0.core_en), 32'd0);
      resetN = 1'b0;
      #1;
      chk("midrst_gnt_ack", 32'({b0.gnt, b0.ack}), 32'd0);
      chk("midrst_core", 32'({b0.core_en, b0.core_addr, b0.core_rw, b0.core_wdata}), 32'd0);
      chk("midrst_rdata", 32'({b0.rdata, b0.timeout_err}), 32'd0);
      @(negedge clk);
      core_len[0] = 4;
      q0.push_back('{ack:2'b01, rdata:8'h00, terr:1'b0, addr:7'h33, wdata:8'h44, rw:1'b0});
      resetN = 1'b1;
      wait_ack(0, 100, en_cyc);
      b0.req = 2'b00;

      // Tie after reset: requests held across four transactions alternate 0,1,0,1.
      do_reset();
      core_delay[0] = 1; core_len[0] = 2;
      b0.req_addr0 = 7'h11; b0.req_wdata0 = 8'h01; b0.req_rw0 = 1'b0;
      b0.req_addr1 = 7'h12; b0.req_wdata1 = 8'h02; b0.req_rw1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0)
            q0.push_back('{ack:2'b01, rdata:8'h00, terr:1'b0, addr:7'h11, wdata:8'h01, rw:1'b0});
         else
            q0.push_back('{ack:2'b10, rdata:8'h00, terr:1'b0, addr:7'h12, wdata:8'h02, rw:1'b0});
      end
      b0.req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_ack(0, 60, en_cyc);
         if (i < 3) begin
            gap = 0; got = 1'b0;
            for (int j = 0; j < 10 && !got; j++) begin
               @(negedge clk);
               if (gnt_o[0] != 2'b00) got = 1'b1;
               else gap++;
            end
            chk("tie_idle_gap", 32'(gap), 32'd1);
         end
      end
      b0.req = 2'b00;

      // b1: read to load rdata with 0x5A.
      core_delay[1] = 1; core_len[1] = 3; rd_next[1] = 8'h5A;
      b1.req_addr0 = 7'h2A; b1.req_rw0 = 1'b1; b1.req_wdata0 = 8'h10;
      q1.push_back('{ack:2'b01, rdata:8'h5A, terr:1'b0, addr:7'h2A, wdata:8'h10, rw:1'b1});
      b1.req = 2'b01;
      wait_ack(1, 60, en_cyc);
      b1.req = 2'b00;

      // b1: the core never goes busy. ISSUE lasts 16 cycles, then aborts with rdata kept.
      core_mode[1] = 1; rd_next[1] = 8'hC3;
      b1.req_addr1 = 7'h6B; b1.req_rw1 = 1'b1; b1.req_wdata1 = 8'h99;
      q1.push_back('{ack:2'b10, rdata:8'h5A, terr:1'b1, addr:7'h6B, wdata:8'h99, rw:1'b1});
      b1.req = 2'b10;
      wait_ack(1, 100, en_cyc);
      chk("timeout_issue_cycles", 32'(en_cyc), 32'd16);
      b1.req = 2'b00;

      // b1: busy stuck high aborts. The held tie is then granted to the other requester.
      core_mode[1] = 2; core_delay[1] = 1; core_len[1] = 1;
      b1.req_addr0 = 7'h0C; b1.req_rw0 = 1'b1; b1.req_wdata0 = 8'h3E;
      b1.req_addr1 = 7'h0D; b1.req_rw1 = 1'b0; b1.req_wdata1 = 8'hEE;
      q1.push_back('{ack:2'b01, rdata:8'h5A, terr:1'b1, addr:7'h0C, wdata:8'h3E, rw:1'b1});
      q1.push_back('{ack:2'b10, rdata:8'h5A, terr:1'b0, addr:7'h0D, wdata:8'hEE, rw:1'b0});
      b1.req = 2'b11;
      wait_ack(1, 100, en_cyc);
      core_mode[1] = 0; core_len[1] = 3;
      wait_ack(1, 100, en_cyc);
      b1.req = 2'b00;

      repeat (5) @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
